// File: rtl/mips_multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mips_multicycle_ctrl_pkg
//   Shared encodings for the multicycle MIPS control path: extender modes,
//   ALU function codes, opcode/funct values, FSM state and instruction class
//   encodings, and the record latched by the decode register.
//   Revision: 1.0 - initial release
// ============================================================================
package mips_multicycle_ctrl_pkg;

  localparam int ALU_CODE_W = 4;

  // Immediate extender modes
  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  // ALU function codes
  localparam logic [ALU_CODE_W-1:0] ALU_NOP = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_LUI = 4'd6;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXE_R   = 4'd2,
    EXE_I   = 4'd3,
    EXE_BR  = 4'd4,
    EXE_J   = 4'd5,
    MEM_ADR = 4'd6,
    MEM_RD  = 4'd7,
    MEM_WR  = 4'd8,
    WB_R    = 4'd9,
    WB_I    = 4'd10,
    WB_MEM  = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP  = 4'd0,
    CL_R    = 4'd1,
    CL_IALU = 4'd2,
    CL_LW   = 4'd3,
    CL_SW   = 4'd4,
    CL_BEQ  = 4'd5,
    CL_J    = 4'd6,
    CL_JAL  = 4'd7,
    CL_ILL  = 4'd8
  } class_e;

  typedef struct packed {
    class_e                cls;
    logic [1:0]            ext;
    logic [ALU_CODE_W-1:0] alu;
  } dec_t;

  localparam dec_t DEC_NOP = '{cls: CL_NOP, ext: EXT_ZERO, alu: ALU_NOP};

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// mips_main_decoder
//   Combinational instruction decode: opcode/funct -> instruction class,
//   extender mode and ALU function. Anything outside the supported set
//   decodes to CL_ILL.
//   Ports:
//     opcode  in  6        IR[31:26]
//     funct   in  6        IR[5:0]
//     dec     out dec_t    {class, ext_op, alu_op}
//   Revision: 1.0 - initial release
// ============================================================================
module mips_main_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CL_ILL, ext: EXT_SIGNED, alu: ALU_NOP};
    case (opcode)
      OP_RTYPE: begin
        dec.cls = CL_R;
        case (funct)
          FN_ADDU: dec.alu = ALU_ADD;
          FN_SUBU: dec.alu = ALU_SUB;
          FN_AND:  dec.alu = ALU_AND;
          FN_OR:   dec.alu = ALU_OR;
          FN_SLT:  dec.alu = ALU_SLT;
          default: dec.cls = CL_ILL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.cls = CL_IALU;
        dec.alu = ALU_ADD;
      end
      OP_ANDI: begin
        dec.cls = CL_IALU;
        dec.ext = EXT_ZERO;
        dec.alu = ALU_AND;
      end
      OP_ORI: begin
        dec.cls = CL_IALU;
        dec.ext = EXT_ZERO;
        dec.alu = ALU_OR;
      end
      OP_LUI: begin
        dec.cls = CL_IALU;
        dec.ext = EXT_HIGHPOS;
        dec.alu = ALU_LUI;
      end
      OP_LW: begin
        dec.cls = CL_LW;
        dec.alu = ALU_ADD;
      end
      OP_SW: begin
        dec.cls = CL_SW;
        dec.alu = ALU_ADD;
      end
      OP_BEQ: begin
        dec.cls = CL_BEQ;
        dec.alu = ALU_SUB;
      end
      OP_J:    dec.cls = CL_J;
      OP_JAL:  dec.cls = CL_JAL;
      default: dec.cls = CL_ILL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// mips_multicycle_ctrl
//   Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback
//   sequencing and all datapath strobes, with a mem_ready stall handshake.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     opcode, funct       instruction fields from the IR
//     zero                ALU zero flag (used in EXE_BR)
//     mem_ready           memory accepted/returned the current access
//     pc_wr, ir_wr        PC / IR load strobes
//     reg_wr              register file write strobe
//     mem_rd, mem_wr      memory read / data write requests
//     i_or_d              memory address select (0 PC, 1 ALUOut)
//     ext_op              immediate extender mode
//     alu_src_b, alu_op   ALU operand B select and function
//     reg_dst, wd_sel     register write index and data selects
//     npc_op              next-PC select
//     illegal             one-cycle pulse on an unsupported instruction
//   Revision: 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int JAL_REG = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               reg_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               i_or_d,
  output logic [1:0]         ext_op,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wd_sel,
  output logic [1:0]         npc_op,
  output logic               illegal
);

  state_e                state, state_next;
  logic                  run;
  dec_t                  dec_now, dec_q;
  logic [ALU_CODE_W-1:0] alu_code;

  // The link register index is muxed in the datapath; only a non-standard
  // choice is worth flagging in the elaborated hierarchy.
  if (JAL_REG != 31) begin : g_nonstd_link_reg
  end

  mips_main_decoder u_dec (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec_now)
  );

  // run holds outputs at zero between reset release and the first clock
  // edge, so FETCH cannot present a request while reset is still settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      run   <= 1'b0;
      dec_q <= DEC_NOP;
    end else begin
      run   <= 1'b1;
      state <= state_next;
      if (run && state == DECODE) dec_q <= dec_now;
    end
  end

  always_comb begin
    state_next = state;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    i_or_d     = 1'b0;
    ext_op     = EXT_ZERO;
    alu_src_b  = 2'd0;
    alu_code   = ALU_NOP;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    npc_op     = 2'd0;
    illegal    = 1'b0;
    if (!run) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'd1;
          alu_code  = ALU_ADD;
          pc_wr     = mem_ready;
          ir_wr     = mem_ready;
          if (mem_ready) state_next = DECODE;
        end
        DECODE: begin
          // Class is not yet registered here, so decode straight off the IR.
          ext_op = dec_now.ext;
          case (dec_now.cls)
            CL_R:         state_next = EXE_R;
            CL_IALU:      state_next = EXE_I;
            CL_LW, CL_SW: state_next = MEM_ADR;
            CL_BEQ:       state_next = EXE_BR;
            CL_J, CL_JAL: state_next = EXE_J;
            default: begin
              illegal    = 1'b1;
              state_next = FETCH;
            end
          endcase
        end
        EXE_R: begin
          alu_code   = dec_q.alu;
          state_next = WB_R;
        end
        WB_R: begin
          reg_wr     = 1'b1;
          reg_dst    = 2'd1;
          state_next = FETCH;
        end
        EXE_I: begin
          alu_src_b  = 2'd2;
          alu_code   = dec_q.alu;
          state_next = WB_I;
        end
        WB_I: begin
          reg_wr     = 1'b1;
          state_next = FETCH;
        end
        MEM_ADR: begin
          alu_src_b  = 2'd2;
          alu_code   = ALU_ADD;
          state_next = (dec_q.cls == CL_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_rd = 1'b1;
          i_or_d = 1'b1;
          if (mem_ready) state_next = WB_MEM;
        end
        WB_MEM: begin
          reg_wr     = 1'b1;
          wd_sel     = 2'd1;
          state_next = FETCH;
        end
        MEM_WR: begin
          mem_wr = 1'b1;
          i_or_d = 1'b1;
          if (mem_ready) state_next = FETCH;
        end
        EXE_BR: begin
          alu_code   = ALU_SUB;
          npc_op     = 2'd1;
          pc_wr      = zero;
          state_next = FETCH;
        end
        EXE_J: begin
          pc_wr  = 1'b1;
          npc_op = 2'd2;
          if (dec_q.cls == CL_JAL) begin
            reg_wr  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
          state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
      // ext_op latched in DECODE stays on the extender until the next fetch.
      if (state inside {EXE_R, WB_R, EXE_I, WB_I, MEM_ADR, MEM_RD, WB_MEM,
                        MEM_WR, EXE_BR, EXE_J}) begin
        ext_op = dec_q.ext;
      end
    end
  end

  assign alu_op = ALUOP_W'(alu_code);

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips_multicycle_ctrl
//   Self-checking bench for mips_multicycle_ctrl: instruction vectors with
//   expected per-instruction strobe summaries, queued as expectations and
//   compared when the FSM returns to FETCH, plus reset sequences.
//   Revision: 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, illegal;
  logic [1:0] ext_op, alu_src_b, reg_dst, wd_sel, npc_op;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.ALUOP_W(4), .JAL_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .i_or_d(i_or_d), .ext_op(ext_op),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .npc_op(npc_op), .illegal(illegal)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fstall;    // mem_ready low cycles in FETCH
    int         dstall;    // mem_ready low cycles in MEM_RD/MEM_WR
    int         cycles;
    int         n_reg_wr;
    int         wr_cycle;  // cycle index of reg_wr, 0 if none
    int         dst;
    int         wd;
    int         ext;
    int         n_pc_wr;
    int         npc;       // npc_op at the last pc_wr
    int         n_ill;
    int         n_mem_wr;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   at_fetch = 1'b0;
  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string nm, logic [5:0] op, logic [5:0] fn,
                              logic z, int fs, int ds, int cyc, int nrw,
                              int wc, int dst, int wd, int ext, int npw,
                              int npc, int nill, int nmw);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.z = z; v.fstall = fs; v.dstall = ds;
    v.cycles = cyc; v.n_reg_wr = nrw; v.wr_cycle = wc; v.dst = dst;
    v.wd = wd; v.ext = ext; v.n_pc_wr = npw; v.npc = npc; v.n_ill = nill;
    v.n_mem_wr = nmw;
    return v;
  endfunction

  function automatic int outs();
    return int'({pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, i_or_d, ext_op,
                 alu_src_b, alu_op, reg_dst, wd_sel, npc_op, illegal});
  endfunction

  task automatic chk(string what, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", what, act, exp);
    end
  endtask

  // Runs one instruction starting in FETCH; ends at the negedge of the next
  // FETCH cycle with mem_ready still undecided (at_fetch = 1).
  task automatic exec(vec_t v);
    vec_t e;
    int cyc = 0, nrw = 0, wc = 0, dst = 0, wd = 0, npw = 0, npc = 0;
    int nir = 0, nill = 0, nmw = 0, fcnt = 0, dcnt = 0, ext_val = -1;
    bit seen_ir = 1'b0, armed = 1'b0, got = 1'b0, stable = 1'b1, done = 1'b0;
    exp_q.push_back(v);
    opcode = v.op; funct = v.fn; zero = v.z;
    for (int i = 0; i < 60; i++) begin
      if (!at_fetch) @(negedge clk);
      at_fetch = 1'b0;
      if (seen_ir && mem_rd && !i_or_d) begin
        at_fetch = 1'b1;
        done = 1'b1;
        break;
      end
      if (mem_rd && !i_or_d) begin
        mem_ready = (fcnt >= v.fstall);
        if (!mem_ready) fcnt++;
      end else if (i_or_d) begin
        mem_ready = (dcnt >= v.dstall);
        if (!mem_ready) dcnt++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      cyc++;
      if (armed) begin
        if (!got) begin ext_val = int'(ext_op); got = 1'b1; end
        else if (int'(ext_op) != ext_val) stable = 1'b0;
      end
      if (reg_wr) begin nrw++; wc = cyc; dst = int'(reg_dst); wd = int'(wd_sel); end
      if (pc_wr)  begin npw++; npc = int'(npc_op); end
      if (illegal) nill++;
      if (mem_wr)  nmw++;
      if (ir_wr)   begin nir++; seen_ir = 1'b1; armed = 1'b1; end
    end
    e = exp_q.pop_front();
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no return to FETCH within 60 cycles", e.name);
    end
    chk({e.name, " cycles"},   cyc,  e.cycles);
    chk({e.name, " reg_wr#"},  nrw,  e.n_reg_wr);
    chk({e.name, " wr_cycle"}, wc,   e.wr_cycle);
    chk({e.name, " reg_dst"},  dst,  e.dst);
    chk({e.name, " wd_sel"},   wd,   e.wd);
    chk({e.name, " ext_op"},   ext_val, e.ext);
    chk({e.name, " ext_hold"}, int'(stable), 1);
    chk({e.name, " pc_wr#"},   npw,  e.n_pc_wr);
    chk({e.name, " npc_op"},   npc,  e.npc);
    chk({e.name, " ir_wr#"},   nir,  1);
    chk({e.name, " illegal#"}, nill, e.n_ill);
    chk({e.name, " mem_wr#"},  nmw,  e.n_mem_wr);
  endtask

  initial begin
    int nwr;
    //             name        op     fn     z  fs ds cyc nrw wc dst wd ext          npw npc ill mw
    vecs.push_back(mk("addu",   6'h00, 6'h21, 0, 0, 0, 4, 1, 4, 1, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("subu",   6'h00, 6'h23, 0, 0, 0, 4, 1, 4, 1, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("and",    6'h00, 6'h24, 0, 0, 0, 4, 1, 4, 1, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("or",     6'h00, 6'h25, 0, 0, 0, 4, 1, 4, 1, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("slt",    6'h00, 6'h2A, 0, 0, 0, 4, 1, 4, 1, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("ori",    6'h0D, 6'h3F, 0, 0, 0, 4, 1, 4, 0, 0, EXT_ZERO,    1, 0, 0, 0));
    vecs.push_back(mk("andi",   6'h0C, 6'h00, 0, 0, 0, 4, 1, 4, 0, 0, EXT_ZERO,    1, 0, 0, 0));
    vecs.push_back(mk("lui",    6'h0F, 6'h00, 0, 0, 0, 4, 1, 4, 0, 0, EXT_HIGHPOS, 1, 0, 0, 0));
    vecs.push_back(mk("addi",   6'h08, 6'h00, 0, 0, 0, 4, 1, 4, 0, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("addiu",  6'h09, 6'h00, 0, 0, 0, 4, 1, 4, 0, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("lw",     6'h23, 6'h00, 0, 0, 0, 5, 1, 5, 0, 1, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("lw_st3", 6'h23, 6'h00, 0, 0, 3, 8, 1, 8, 0, 1, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("sw",     6'h2B, 6'h00, 0, 0, 0, 4, 0, 0, 0, 0, EXT_SIGNED,  1, 0, 0, 1));
    vecs.push_back(mk("sw_st2", 6'h2B, 6'h00, 0, 0, 2, 6, 0, 0, 0, 0, EXT_SIGNED,  1, 0, 0, 3));
    vecs.push_back(mk("beq_z1", 6'h04, 6'h00, 1, 0, 0, 3, 0, 0, 0, 0, EXT_SIGNED,  2, 1, 0, 0));
    vecs.push_back(mk("beq_z0", 6'h04, 6'h00, 0, 0, 0, 3, 0, 0, 0, 0, EXT_SIGNED,  1, 0, 0, 0));
    vecs.push_back(mk("j",      6'h02, 6'h00, 0, 0, 0, 3, 0, 0, 0, 0, EXT_SIGNED,  2, 2, 0, 0));
    vecs.push_back(mk("jal",    6'h03, 6'h00, 0, 0, 0, 3, 1, 3, 2, 2, EXT_SIGNED,  2, 2, 0, 0));
    vecs.push_back(mk("ill_op", 6'h3F, 6'h00, 0, 0, 0, 2, 0, 0, 0, 0, EXT_SIGNED,  1, 0, 1, 0));
    vecs.push_back(mk("ill_fn", 6'h00, 6'h00, 0, 0, 0, 2, 0, 0, 0, 0, EXT_SIGNED,  1, 0, 1, 0));
    vecs.push_back(mk("f_st2",  6'h00, 6'h21, 0, 2, 0, 6, 1, 6, 1, 0, EXT_SIGNED,  1, 0, 0, 0));

    // Power-on reset: everything quiet while rst_n is low.
    repeat (3) @(negedge clk);
    #1 chk("reset outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post-release pre-edge outputs", outs(), 0);
    @(posedge clk);
    @(negedge clk);
    chk("fetch mem_rd", int'(mem_rd), 1);
    chk("fetch i_or_d", int'(i_or_d), 0);
    chk("fetch alu_src_b", int'(alu_src_b), 1);
    chk("fetch stall pc_wr", int'(pc_wr), 0);
    at_fetch = 1'b1;

    foreach (vecs[k]) exec(vecs[k]);

    // sw stalled in MEM_WR, then reset dropped mid-access.
    opcode = OP_SW; funct = 6'h00; nwr = 0;
    for (int i = 0; i < 30; i++) begin
      if (!at_fetch) @(negedge clk);
      at_fetch = 1'b0;
      mem_ready = !i_or_d;
      #1;
      if (mem_wr) nwr++;
      if (nwr == 3) break;
    end
    chk("sw mem_wr held in stall", nwr, 3);
    #2 rst_n = 1'b0;
    #1 chk("async reset mem_wr", int'(mem_wr), 0);
    chk("async reset outputs", outs(), 0);
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 chk("held reset outputs", outs(), 0);
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart mem_rd", int'(mem_rd), 1);
    chk("restart i_or_d", int'(i_or_d), 0);
    chk("restart mem_wr", int'(mem_wr), 0);
    at_fetch = 1'b1;
    exec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
